// File: rtl/regfile_writeback.sv
// regfile_writeback
// Write-side front end for the 32x32 register file. Results from the
// single-cycle ALU and the multi-cycle mul/div unit are accepted with
// valid/ready handshakes and kept in an in-order FIFO. One entry per cycle
// is written through the register file's single write port. A bitmask of
// registers with queued writes is published for the hazard logic.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_valid/addr/data, alu_ready ALU producer handshake (fixed priority)
//   mul_valid/addr/data, mul_ready mul/div producer handshake
//   stall                          write port unavailable this cycle
//   we, writeaddr, writedata       register-file write port (head entry)
//   pending                        bit i set while a write to reg i is queued
//   count                          FIFO occupancy, 0..DEPTH
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_addr,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       mul_valid,
  input  logic [4:0]                 mul_addr,
  input  logic [31:0]                mul_data,
  output logic                       mul_ready,
  input  logic                       stall,
  output logic                       we,
  output logic [4:0]                 writeaddr,
  output logic [31:0]                writedata,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          not_full;
  logic          acc_alu, acc_mul;
  logic          enq, deq;
  logic [4:0]    enq_addr;
  logic [31:0]   enq_data;

  function automatic logic [31:0] onehot5(input logic [4:0] a);
    onehot5 = 32'd1 << a;
  endfunction

  // Readiness depends only on registered occupancy, so a full FIFO refuses
  // input even in a cycle where it is draining.
  assign not_full  = (count_q < CW'(DEPTH));
  assign alu_ready = not_full;
  assign mul_ready = not_full && !alu_valid;

  assign acc_alu  = alu_valid && alu_ready;
  assign acc_mul  = mul_valid && mul_ready;
  assign enq_addr = acc_alu ? alu_addr : mul_addr;
  assign enq_data = acc_alu ? alu_data : mul_data;
  // Writes to r0 complete the handshake but are dropped here.
  assign enq      = (acc_alu || acc_mul) && (enq_addr != 5'd0);
  assign deq      = (count_q != '0) && !stall;

  assign we        = deq;
  assign writeaddr = (count_q != '0) ? addr_q[rd_ptr_q] : 5'd0;
  assign writedata = (count_q != '0) ? data_q[rd_ptr_q] : 32'd0;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is occupied when its distance from the read pointer (modulo
  // DEPTH) is below the occupancy count.
  always_comb begin
    logic [AW-1:0] off;
    pending = 32'd0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q)
        pending = pending | onehot5(addr_q[i]);
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr_q] <= enq_addr;
        data_q[wr_ptr_q] <= enq_data;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (deq)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 32x32 register file: collects register results from two producers (single-cycle ALU and a multi-cycle multiply/divide unit), buffers them in an in-order FIFO, and drives the register file's single write port (`we`, `writeaddr`, `writedata`) one write per cycle. It arbitrates between the producers with valid/ready handshakes. It absorbs cycles where the write port is held off by `stall`. It publishes a per-register pending bitmask for the hazard logic.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, >= 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_addr`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` is also 1.
- `mul_valid`  in  1  mul/div result offered.
- `mul_addr`  in  5  mul/div destination register.
- `mul_data`  in  32  mul/div result.
- `mul_ready`  out  1  mul/div result accepted this cycle when `mul_valid` is also 1.
- `stall`  in  1  write port unavailable this cycle; no dequeue.
- `we`  out  1  register-file write enable.
- `writeaddr`  out  5  register-file write address.
- `writedata`  out  32  register-file write data.
- `pending`  out  32  bit i = 1 while a write to register i is queued and not yet issued.
- `count`  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- The FIFO holds {addr, data} entries with a write pointer, a read pointer and an occupancy counter, all registered.
- Arbitration:
  - `alu_ready = (count < DEPTH)`.
  - `mul_ready = (count < DEPTH) && !alu_valid`.
  - The ALU has fixed priority. At most one enqueue per cycle.
- Handshake: a transfer occurs on a rising edge where valid && ready. The producer holds addr/data stable until that edge.
- Accepted transfers with addr == 0 complete the handshake but are discarded: no enqueue, no change to `count`.
- Dequeue: a dequeue occurs on each rising edge where `count > 0 && !stall`.
  - `we = (count > 0) && !stall`.
  - `writeaddr` and `writedata` show the head entry whenever `count > 0`, and are 0 when `count == 0`.
- Ordering:
  - Entries issue strictly in acceptance order.
  - Two queued writes to the same register both issue, so the later value lands last.
- `pending`:
  - Computed combinationally as the OR of the one-hot decode of `addr` over all occupied entries.
  - `pending[0]` is always 0.
  - A bit clears in the cycle after its last matching entry is dequeued.
- Simultaneous enqueue and dequeue: both take effect and `count` is unchanged.
- Ready never depends combinationally on `stall` or on the same-cycle dequeue. A full FIFO refuses input even while draining that cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - Clears both pointers, `count` and all entries to 0.
  - Output values: `we` = 0, `writeaddr` = 0, `writedata` = 0, `pending` = 0, `count` = 0, `alu_ready` = 1, and `mul_ready` = !`alu_valid`.
- Reset asserted mid-operation drops all queued writes immediately; no further `we` pulses occur.
- Reset release is synchronous to `clk` in the surrounding design. The first handshake can complete on the first rising edge after release.
- Latency: a handshake at edge N into an empty FIFO with `stall` = 0 presents `we` = 1 during cycle N..N+1. The register file commits it at edge N+1.
- Throughput: one write per cycle sustained. With `stall` = 0 the occupancy never exceeds 1.
- Full: with `count == DEPTH`, both readies are 0. The first unstalled edge dequeues one entry, and both readies rise in the following cycle.
- Empty with `stall` = 1: no effect; `we` stays 0.

## Test plan
- Reset, then ALU offers addr 5, data 0xDEADBEEF with `stall` = 0 → accepted at edge 1. Cycle after: `we` = 1, `writeaddr` = 5, `writedata` = 0xDEADBEEF, `pending[5]` = 1. Next cycle: `we` = 0, `pending` = 0, `count` = 0.
- ALU and mul/div both valid in the same cycle (addrs 3 and 4) → `mul_ready` = 0 that cycle. Register 3 is written first, then register 4 one cycle after the ALU drops valid.
- Hold `stall` = 1, DEPTH = 4; enqueue addrs 1, 2, 3, 4 → `count` = 4, `pending` = 0x1E, `alu_ready` = 0. A fifth offer stays pending. Release `stall` → writes issue in order 1, 2, 3, 4 on consecutive cycles, with `alu_ready` returning 1 one cycle after the first dequeue.
- ALU offers addr 0, data 0x12345678 → handshake completes, `count` stays 0, `we` never asserts.
- With `stall` = 1, enqueue addr 7 data 0x1 then addr 7 data 0x2 → `pending[7]` = 1. Release `stall` → two writes to 7 with data 0x1 then 0x2, and `pending[7]` clears after the second.
- With 3 entries queued under `stall`, pulse `rst_n` low for half a cycle → all outputs take their reset values immediately, and no `we` pulse follows after release.
